i2c_target_write_rx: RTL and testbench
======================================

Name: i2c_target_write_rx

Overview:
- Bus-side responder for the master core's START/byte traffic: write-only I2C target.
- Watches oversampled SCL/SDA pins and detects START, repeated START and STOP.
- Shifts in the address byte, ACKs its own address on write, then receives data bytes and presents each one as a one-cycle strobe.
- Sits between the board pins (open-drain SDA) and a register/FIFO sink; used to loop back and verify the master core.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this target answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (min 2).

Ports:
- i_clk  in  1  system clock; every SCL high/low phase lasts at least SYNC_STAGES+3 cycles.
- i_rst_n  in  1  asynchronous active-low reset.
- i_scl  in  1  raw SCL pin level.
- i_sda  in  1  raw SDA pin level.
- o_sda_oe  out  1  1 = pull SDA low (ACK); 0 = release.
- o_data  out  8  last received data byte, MSB first on the wire.
- o_data_valid  out  1  one-cycle strobe; o_data is new this cycle.
- o_start  out  1  one-cycle pulse on START or repeated START.
- o_stop  out  1  one-cycle pulse on STOP.
- o_busy  out  1  high from START until STOP.
- o_addr_match  out  1  high from address ACK until the next START or STOP.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, bit counter 0, shift register 0, synchronizer flops 1 (idle bus).
- Synchronize both pins through SYNC_STAGES flops, plus one history flop each. Define scl_rise, scl_fall, sda_rise, sda_fall as prev/current differences.
- START: sda_fall while SCL is high in both prev and current samples. STOP: sda_rise under the same condition. If SDA and SCL change in the same sample, it is neither START nor STOP; the SCL edge is handled normally.
- START and STOP take priority over every state, including mid-byte and mid-ACK:
  - Both release o_sda_oe immediately (next cycle) and clear o_addr_match.
  - START: clears the bit counter, sets o_busy, pulses o_start, goes to ADDR.
  - STOP: pulses o_stop, clears o_busy, goes to IDLE.
- Bit sampling: on scl_rise in ADDR or DATA, shift the current synchronized SDA into the LSB and increment the bit counter. SDA changes while SCL is low are ignored.
- States:
  - IDLE: wait for START.
  - ADDR: after 8th scl_rise, check shift[7:1]==TARGET_ADDR and shift[0]==0 (write).
    - Match: go ADDR_ACK, set o_addr_match.
    - Otherwise (mismatch or read request): go IGNORE; no ACK, SDA never driven.
  - ADDR_ACK / DATA_ACK:
    - Next scl_fall: assert o_sda_oe.
    - Hold through the ACK clock high phase.
    - Following scl_fall: deassert o_sda_oe, clear the bit counter, go DATA.
  - DATA: after 8th scl_rise, load o_data, pulse o_data_valid, go DATA_ACK. Every data byte is ACKed; there is no back-pressure.
  - IGNORE: drive nothing; leave only on START or STOP.
- Latency:
  - o_data_valid and o_start/o_stop assert SYNC_STAGES+1 i_clk cycles after the triggering pin edge.
  - o_sda_oe follows SCL's pin falling edge by SYNC_STAGES+1 cycles.
- Bit counter is 3 bits plus a done flag (values 0..8); no wrap into the next byte without passing through an ACK state.
- A START arriving while in DATA_ACK with o_sda_oe high releases SDA the next cycle.
- The same-sample SDA/SCL rule means glitch-free masters never see false START/STOP.

Decomposition:
- Shared include i2c_defs.vh holds:
  - state encodings (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE, 3-bit);
  - I2C_ACK = 1'b0, I2C_NACK = 1'b1;
  - I2C_RW_WRITE = 1'b0.
- One sub-module: i2c_bus_cond_detect. It holds the synchronizers, history flops and edge/START/STOP decode. Outputs: scl_rise, scl_fall, sda_s, start_det, stop_det. The master side can reuse it for arbitration and bus-busy detection.

Test Plan:
- Reset: hold i_rst_n=0 with pins toggling -> all outputs 0. Release -> o_busy stays 0 until a START.
- Write to own address: START, 0x84 (0x42,W), byte 0xA5, STOP ->
  - o_start pulse;
  - o_sda_oe=1 during both 9th clocks;
  - o_data_valid once with o_data=0xA5;
  - o_stop pulse, o_busy back to 0.
- Address mismatch: START, 0x86, byte 0x11, STOP -> o_sda_oe never 1, no o_data_valid, o_addr_match stays 0, o_stop pulse.
- Read request: START, 0x85 -> NACK (o_sda_oe stays 0), IGNORE until STOP.
- Repeated START mid-byte: START, 0x84, ACK, 3 data bits, then START, 0x84, byte 0x3C, STOP ->
  - second o_start pulse;
  - the partial byte is discarded;
  - exactly one o_data_valid, with o_data=0x3C.
- Multi-byte and async reset: START, 0x84, bytes 0x00, 0xFF, 0x5A ->
  - three strobes in order, each ACKed;
  - async reset asserted while o_sda_oe=1 -> o_sda_oe drops immediately and the state returns to IDLE.

Source files
------------

// File: rtl/i2c_target_write_rx_pkg.sv
// Shared definitions for the write-only I2C target: FSM encoding and bus levels.
package i2c_target_write_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } state_t;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    // True when an address byte selects this target for a write transfer.
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[0] == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// Pin synchronizers plus edge / START / STOP decode for SCL and SDA.
// Reusable by a master for arbitration and bus-busy tracking.
module i2c_bus_cond_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   scl_high;

    // Synchronizer chains and one history flop per pin; reset to an idle (high) bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // SCL must be high in both samples, so a simultaneous SCL change never looks like START/STOP.
    assign scl_high  = scl_prev & scl_s;
    assign scl_rise  = ~scl_prev & scl_s;
    assign scl_fall  = scl_prev & ~scl_s;
    assign start_det = scl_high & sda_prev & ~sda_s;
    assign stop_det  = scl_high & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target_write_rx.sv
// Write-only I2C target: ACKs its own address on write and strobes out each data byte.
module i2c_target_write_rx
    import i2c_target_write_rx_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy,
    output logic       o_addr_match,
    output logic [2:0] o_dbg_state
);

    logic       scl_rise, scl_fall, sda_s, start_det, stop_det;
    state_t     state, state_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       bit_done, bit_done_next;
    logic [7:0] shift, shift_next, shift_in;
    logic [7:0] data_next;
    logic       sda_oe_next, valid_next, start_next, stop_next, busy_next, match_next;
    logic       byte_done, addr_ok;

    i2c_bus_cond_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_scl     (i_scl),
        .i_sda     (i_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign shift_in    = {shift[6:0], sda_s};
    assign byte_done   = scl_rise && !bit_done && (bit_cnt == 3'd7);
    assign addr_ok     = addr_hit(shift_in, TARGET_ADDR);
    assign o_dbg_state = state;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next state: START/STOP override everything; ACK states leave on the second SCL fall.
    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ST_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:     if (byte_done) state_next = addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                ST_DATA:     if (byte_done) state_next = ST_DATA_ACK;
                ST_ADDR_ACK,
                ST_DATA_ACK: if (scl_fall && o_sda_oe) state_next = ST_DATA;
                default:     state_next = state;
            endcase
        end
    end

    // Outputs and datapath next values; o_sda_oe itself marks which half of the ACK we are in.
    always_comb begin
        sda_oe_next   = o_sda_oe;
        data_next     = o_data;
        valid_next    = 1'b0;
        start_next    = 1'b0;
        stop_next     = 1'b0;
        busy_next     = o_busy;
        match_next    = o_addr_match;
        bit_cnt_next  = bit_cnt;
        bit_done_next = bit_done;
        shift_next    = shift;
        if (start_det) begin
            sda_oe_next   = 1'b0;
            match_next    = 1'b0;
            busy_next     = 1'b1;
            start_next    = 1'b1;
            bit_cnt_next  = 3'd0;
            bit_done_next = 1'b0;
            shift_next    = 8'd0;
        end else if (stop_det) begin
            sda_oe_next   = 1'b0;
            match_next    = 1'b0;
            busy_next     = 1'b0;
            stop_next     = 1'b1;
            bit_cnt_next  = 3'd0;
            bit_done_next = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise && !bit_done) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) bit_done_next = 1'b1;
                    end
                    if (byte_done && state == ST_ADDR && addr_ok) match_next = 1'b1;
                    if (byte_done && state == ST_DATA) begin
                        data_next  = shift_in;
                        valid_next = 1'b1;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!o_sda_oe) begin
                            sda_oe_next = (I2C_ACK == 1'b0);
                        end else begin
                            sda_oe_next   = 1'b0;
                            bit_cnt_next  = 3'd0;
                            bit_done_next = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register outputs and datapath so every output is glitch-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sda_oe     <= 1'b0;
            o_data       <= 8'd0;
            o_data_valid <= 1'b0;
            o_start      <= 1'b0;
            o_stop       <= 1'b0;
            o_busy       <= 1'b0;
            o_addr_match <= 1'b0;
            bit_cnt      <= 3'd0;
            bit_done     <= 1'b0;
            shift        <= 8'd0;
        end else begin
            o_sda_oe     <= sda_oe_next;
            o_data       <= data_next;
            o_data_valid <= valid_next;
            o_start      <= start_next;
            o_stop       <= stop_next;
            o_busy       <= busy_next;
            o_addr_match <= match_next;
            bit_cnt      <= bit_cnt_next;
            bit_done     <= bit_done_next;
            shift        <= shift_next;
        end
    end

endmodule

// File: tb/tb_i2c_target_write_rx.sv
// Bench for the write-only I2C target: bit-banged master, open-drain bus, data scoreboard.
module tb_i2c_target_write_rx;
    import i2c_target_write_rx_pkg::*;

    localparam int Q   = 4;   // quarter SCL period in clk cycles
    localparam int H   = 8;   // SCL high phase in clk cycles
    localparam int LAT = 3;   // SYNC_STAGES + 1

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       o_sda_oe;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_start;
    logic       o_stop;
    logic       o_busy;
    logic       o_addr_match;
    logic [2:0] o_dbg_state;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] exp_q[$];

    // Open-drain SDA: master and target both only pull low.
    assign sda_bus = sda_m & ~o_sda_oe;

    i2c_target_write_rx dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_scl        (scl),
        .i_sda        (sda_bus),
        .o_sda_oe     (o_sda_oe),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_start      (o_start),
        .o_stop       (o_stop),
        .o_busy       (o_busy),
        .o_addr_match (o_addr_match),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (o_start === 1'b1) start_cnt++;
        if (o_stop === 1'b1) stop_cnt++;
        if (o_sda_oe === 1'b1) oe_cnt++;
        if (o_data_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL data_unexpected: got %02h, none expected", o_data);
            end else begin
                logic [7:0] exp;
                exp = exp_q.pop_front();
                if (o_data !== exp) begin
                    errors++;
                    $display("FAIL data_byte: got %02h, expected %02h", o_data, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Byte plus ACK clock; reports whether the target pulled SDA low mid-high-phase.
    task automatic send_byte(input logic [7:0] b, output logic ack_seen);
        send_bits(b);
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H / 2);
        ack_seen = o_sda_oe & ~sda_bus;
        wait_clk(H / 2);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    // START (or repeated START) from SCL low or idle; returns cycles to the o_start pulse.
    task automatic i2c_start(output int lat);
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_start === 1'b1) break;
        end
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop(output int lat);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_stop === 1'b1) break;
        end
        wait_clk(Q);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            scl   = 1'(i % 2);
            sda_m = 1'(i % 3 == 0);
        end
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b, expected 0", o_sda_oe); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h, expected 00", o_data); end
        checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", o_data_valid); end
        checks++; if (o_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, expected 0", o_start); end
        checks++; if (o_stop !== 1'b0) begin errors++; $display("FAIL rst_stop: got %b, expected 0", o_stop); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", o_busy); end
        checks++; if (o_addr_match !== 1'b0) begin errors++; $display("FAIL rst_match: got %b, expected 0", o_addr_match); end
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, expected %0d", o_dbg_state, ST_IDLE); end
        scl = 1'b1;
        sda_m = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(20);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b, expected 0", o_busy); end
        checks++; if (start_cnt != 0) begin errors++; $display("FAIL post_rst_start: got %0d pulses, expected 0", start_cnt); end
    endtask

    task automatic test_write_own();
        int lat;
        logic ack;
        int v0, s0, p0;
        v0 = valid_cnt; s0 = start_cnt; p0 = stop_cnt;
        i2c_start(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL wr_start_lat: got %0d, expected %0d", lat, LAT); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, expected 1", o_busy); end
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got %b, expected 1", ack); end
        checks++; if (o_addr_match !== 1'b1) begin errors++; $display("FAIL wr_match: got %b, expected 1", o_addr_match); end
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_data_ack: got %b, expected 1", ack); end
        i2c_stop(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL wr_stop_lat: got %0d, expected %0d", lat, LAT); end
        wait_clk(2);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b, expected 0", o_busy); end
        checks++; if (o_addr_match !== 1'b0) begin errors++; $display("FAIL wr_match_end: got %b, expected 0", o_addr_match); end
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL wr_valid_cnt: got %0d, expected 1", valid_cnt - v0); end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL wr_start_cnt: got %0d, expected 1", start_cnt - s0); end
        checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL wr_stop_cnt: got %0d, expected 1", stop_cnt - p0); end
    endtask

    task automatic test_addr_mismatch();
        int lat;
        logic ack;
        int v0, p0, o0;
        v0 = valid_cnt; p0 = stop_cnt; o0 = oe_cnt;
        i2c_start(lat);
        send_byte(8'h86, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mm_addr_ack: got %b, expected 0", ack); end
        checks++; if (o_addr_match !== 1'b0) begin errors++; $display("FAIL mm_match: got %b, expected 0", o_addr_match); end
        send_byte(8'h11, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mm_data_ack: got %b, expected 0", ack); end
        i2c_stop(lat);
        wait_clk(2);
        checks++; if (oe_cnt != o0) begin errors++; $display("FAIL mm_sda_oe: got %0d driven cycles, expected 0", oe_cnt - o0); end
        checks++; if (valid_cnt != v0) begin errors++; $display("FAIL mm_valid: got %0d strobes, expected 0", valid_cnt - v0); end
        checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL mm_stop: got %0d pulses, expected 1", stop_cnt - p0); end
    endtask

    task automatic test_read_request();
        int lat;
        logic ack;
        int o0;
        o0 = oe_cnt;
        i2c_start(lat);
        send_byte(8'h85, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_ack: got %b, expected 0", ack); end
        checks++; if (o_dbg_state !== ST_IGNORE) begin errors++; $display("FAIL rd_state: got %0d, expected %0d", o_dbg_state, ST_IGNORE); end
        send_byte(8'hFF, ack);
        i2c_stop(lat);
        wait_clk(2);
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL rd_state_end: got %0d, expected %0d", o_dbg_state, ST_IDLE); end
        checks++; if (oe_cnt != o0) begin errors++; $display("FAIL rd_sda_oe: got %0d driven cycles, expected 0", oe_cnt - o0); end
    endtask

    task automatic test_repeated_start();
        int lat;
        logic ack;
        int v0, s0;
        v0 = valid_cnt; s0 = start_cnt;
        i2c_start(lat);
        send_byte(8'h84, ack);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_start(lat);
        checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL rs_start_cnt: got %0d, expected 2", start_cnt - s0); end
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rs_addr_ack: got %b, expected 1", ack); end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, ack);
        i2c_stop(lat);
        wait_clk(2);
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL rs_valid_cnt: got %0d, expected 1", valid_cnt - v0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rs_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int waited;
        logic ack;
        int v0;
        logic [7:0] bytes [3];
        logic [7:0] rnd;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
        v0 = valid_cnt;
        i2c_start(lat);
        send_byte(8'h84, ack);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            send_byte(bytes[i], ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b, expected 1", i, ack); end
        end
        rnd = 8'($urandom_range(0, 255));
        exp_q.push_back(rnd);
        send_bits(rnd);
        sda_m = 1'b1;
        waited = 0;
        while (o_sda_oe !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (o_sda_oe !== 1'b1) begin errors++; $display("FAIL b2b_ack_drive: got %b, expected 1", o_sda_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL arst_sda_oe: got %b, expected 0", o_sda_oe); end
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL arst_state: got %0d, expected %0d", o_dbg_state, ST_IDLE); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b, expected 0", o_busy); end
        wait_clk(2);
        scl = 1'b1;
        sda_m = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(5);
        checks++; if (valid_cnt - v0 != 4) begin errors++; $display("FAIL b2b_valid_cnt: got %0d, expected 4", valid_cnt - v0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        test_reset();
        test_write_own();
        test_addr_mismatch();
        test_read_request();
        test_repeated_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
